// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: turns each 32-bit instruction request into four byte reads
// on the 8-bit memory bus and returns the little-endian word with a one-cycle
// valid pulse. busy_o stalls the PC while a fetch is in flight; flush_i aborts it.
// Optional I-cache: define ICACHE_EN for a direct-mapped cache of ICACHE_LINES
// one-word lines (hit returns the word one cycle after accept).
module inst_fetch_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_din_i
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_rd_q, mem_rd_d;
  logic [23:0]       part_q, part_d;      // bytes 0..2 of the word being assembled
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              hit;
  logic [31:0]       hit_word;
  logic              fill;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of 2 and at least 2");
  end

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  // Tag keeps the two byte-offset bits as well, so an unaligned request never
  // hits a line filled from a different byte address.
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ICACHE_LINES-1:0] line_vld_q;
  logic [31:0]             line_data_q [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
  logic [IDX_W-1:0]        look_idx, fill_idx;
  logic [TAG_W-1:0]        look_tag, fill_tag;

  // Lookup uses the incoming address; fill uses the latched base.
  always_comb begin
    look_idx = addr_i[IDX_W+1:2];
    look_tag = {addr_i[ADDR_W-1:IDX_W+2], addr_i[1:0]};
    fill_idx = base_q[IDX_W+1:2];
    fill_tag = {base_q[ADDR_W-1:IDX_W+2], base_q[1:0]};
    hit      = line_vld_q[look_idx] && (line_tag_q[look_idx] == look_tag);
    hit_word = line_data_q[look_idx];
  end

  // Valid bits: cleared by reset only, set when a miss completes.
  always_ff @(posedge clk) begin
    if (rst)       line_vld_q <= '0;
    else if (fill) line_vld_q[fill_idx] <= 1'b1;
  end

  // Line data/tag storage, no reset needed (guarded by the valid bits).
  always_ff @(posedge clk) begin
    if (fill) begin
      line_data_q[fill_idx] <= inst_d;
      line_tag_q[fill_idx]  <= fill_tag;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  // Next-state and registered-output logic; flush overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    mem_a_d      = mem_a_q;
    mem_rd_d     = mem_rd_q;
    part_d       = part_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fill         = 1'b0;
    if (flush_i) begin
      state_d  = IDLE;
      mem_rd_d = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          cnt_d = cnt_q + 3'd1;
          // Data for the address driven in cnt k-1 arrives during cnt k.
          case (cnt_q)
            3'd1: part_d[7:0]   = mem_din_i;
            3'd2: part_d[15:8]  = mem_din_i;
            3'd3: part_d[23:16] = mem_din_i;
            3'd4: begin
              inst_d       = {mem_din_i, part_q};
              inst_valid_d = 1'b1;
              fill         = 1'b1;
              state_d      = DONE;
              cnt_d        = 3'd0;
            end
            default: ;
          endcase
          if (cnt_q < 3'd3) begin
            mem_a_d  = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
            mem_rd_d = 1'b1;
          end else begin
            mem_rd_d = 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          state_d = IDLE;
          if (req_i) begin
            base_d = addr_i;
            cnt_d  = 3'd0;
            if (hit) begin
              state_d      = DONE;
              inst_d       = hit_word;
              inst_valid_d = 1'b1;
            end else begin
              state_d  = FETCH;
              mem_a_d  = addr_i;
              mem_rd_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      base_q       <= '0;
      mem_a_q      <= '0;
      mem_rd_q     <= 1'b0;
      part_q       <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      mem_a_q      <= mem_a_d;
      mem_rd_q     <= mem_rd_d;
      part_q       <= part_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign busy_o       = (state_q == FETCH);
  assign mem_a_o      = mem_a_q;
  assign mem_rd_o     = mem_rd_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus randomized fetches checked
// against a word/latency model (and a line-address cache model when ICACHE_EN).
module tb_inst_fetch_ctrl;
  localparam int ADDR_W = 32;
  localparam int LINES  = 64;

  logic              clk = 1'b0;
  logic              rst, req_i, flush_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       inst_o;
  logic              inst_valid_o, busy_o, mem_rd_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_din_i = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;

  inst_fetch_ctrl #(.ADDR_W(ADDR_W), .ICACHE_LINES(LINES)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .busy_o(busy_o),
    .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  // Memory: explicit bytes where written, hashed contents elsewhere.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] t;
    if (mem.exists(a)) return mem[a];
    t = a * 32'h9E3779B1;
    return t[31:24];
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  // Read data appears the cycle after the address; junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_o) begin
      mem_din_i <= mbyte(mem_a_o);
      rd_cnt    <= rd_cnt + 1;
    end else begin
      mem_din_i <= 8'($urandom);
    end
  end

  // Cache model: which full byte address each line currently holds.
  logic [31:0] c_addr [LINES];
  bit          c_vld  [LINES];

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef ICACHE_EN
    return c_vld[line_of(a)] && (c_addr[line_of(a)] == a);
`else
    return 1'b0 && (a == c_addr[0]);
`endif
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    c_vld[line_of(a)]  = 1'b1;
    c_addr[line_of(a)] = a;
  endfunction

  task automatic apply_reset;
    rst = 1'b1; req_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (c_vld[i]) c_vld[i] = 1'b0;
  endtask

  // Issue one request at a negedge; optionally pulse flush in cycle flush_at.
  // lat = cycle of the valid pulse after the accept edge, 0 if none within 20.
  task automatic fetch(input logic [31:0] a, input int flush_at,
                       output logic [31:0] w, output int lat);
    w = '0; lat = 0;
    req_i = 1'b1; addr_i = a;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0; addr_i = $urandom;
    for (int c = 1; c <= 20; c++) begin
      if (inst_valid_o === 1'b1) begin lat = c; w = inst_o; break; end
      flush_i = (c == flush_at);
      @(negedge clk);
    end
    flush_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; addr_i = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (inst_o !== 32'h0) $display("FAIL reset_inst got %h want 0", inst_o); else n_pass++;
    n_checks++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", inst_valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (mem_rd_o !== 1'b0) $display("FAIL reset_rd got %b want 0", mem_rd_o); else n_pass++;
    n_checks++; if (mem_a_o !== 32'h0) $display("FAIL reset_addr got %h want 0", mem_a_o); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
    req_i = 1'b1; addr_i = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_checks++; if (mem_rd_o !== (c <= 4)) $display("FAIL single_rd c%0d got %b want %b", c, mem_rd_o, c <= 4); else n_pass++;
      n_checks++; if (busy_o !== (c <= 5)) $display("FAIL single_busy c%0d got %b want %b", c, busy_o, c <= 5); else n_pass++;
      n_checks++; if (inst_valid_o !== (c == 6)) $display("FAIL single_valid c%0d got %b want %b", c, inst_valid_o, c == 6); else n_pass++;
      if (c <= 4) begin
        n_checks++;
        if (mem_a_o !== 32'h100 + 32'(c - 1)) $display("FAIL single_addr c%0d got %h want %h", c, mem_a_o, 32'h100 + 32'(c - 1));
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (inst_o !== 32'h00100513) $display("FAIL single_word got %h want 00100513", inst_o); else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int nv;
    req_i = 1'b1; addr_i = 32'h600;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (inst_o !== 32'h0) $display("FAIL rstmid_inst got %h want 0", inst_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || mem_rd_o !== 1'b0 || inst_valid_o !== 1'b0)
      $display("FAIL rstmid_ctl got busy=%b rd=%b v=%b want 0", busy_o, mem_rd_o, inst_valid_o); else n_pass++;
    n_checks++; if (mem_a_o !== 32'h0) $display("FAIL rstmid_addr got %h want 0", mem_a_o); else n_pass++;
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (inst_valid_o === 1'b1) nv++;
      @(negedge clk);
    end
    n_checks++; if (nv != 0) $display("FAIL rstmid_novalid got %0d pulses want 0", nv); else n_pass++;
    foreach (c_vld[i]) c_vld[i] = 1'b0;
  endtask

  task automatic test_back_to_back;
    int vc[$];
    logic [31:0] vw[$];
    int c0, c1;
    logic [31:0] w0, w1;
    req_i = 1'b1; addr_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    addr_i = 32'h4;
    for (int c = 1; c <= 14; c++) begin
      if (inst_valid_o === 1'b1) begin
        vc.push_back(c); vw.push_back(inst_o);
        if (vc.size() == 2) req_i = 1'b0;
      end
      @(negedge clk);
    end
    req_i = 1'b0;
    c0 = (vc.size() > 0) ? vc[0] : -1;  w0 = (vw.size() > 0) ? vw[0] : 32'hx;
    c1 = (vc.size() > 1) ? vc[1] : -1;  w1 = (vw.size() > 1) ? vw[1] : 32'hx;
    n_checks++; if (vc.size() != 2) $display("FAIL b2b_count got %0d want 2", vc.size()); else n_pass++;
    n_checks++; if (c0 != 6) $display("FAIL b2b_first_cycle got %0d want 6", c0); else n_pass++;
    n_checks++; if (c1 != 12) $display("FAIL b2b_second_cycle got %0d want 12", c1); else n_pass++;
    n_checks++; if (w0 !== exp_word(32'h0)) $display("FAIL b2b_word0 got %h want %h", w0, exp_word(32'h0)); else n_pass++;
    n_checks++; if (w1 !== exp_word(32'h4)) $display("FAIL b2b_word1 got %h want %h", w1, exp_word(32'h4)); else n_pass++;
  endtask

  task automatic test_flush;
    logic [31:0] w, prev;
    int lat, nv;
    fetch(32'h300, 0, w, lat);
    prev = exp_word(32'h300);
    n_checks++; if (w !== prev || lat != 6) $display("FAIL flush_pre got %h/%0d want %h/6", w, lat, prev); else n_pass++;
    req_i = 1'b1; addr_i = 32'h180;
    @(posedge clk);
    @(negedge clk);            // cycle 1, cnt 0
    req_i = 1'b0;
    @(negedge clk);            // cycle 2, cnt 1
    @(negedge clk);            // cycle 3, cnt 2
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_checks++; if (mem_rd_o !== 1'b0) $display("FAIL flush_rd got %b want 0", mem_rd_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_busy got %b want 0", busy_o); else n_pass++;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (inst_valid_o === 1'b1) nv++;
      @(negedge clk);
    end
    n_checks++; if (nv != 0) $display("FAIL flush_novalid got %0d want 0", nv); else n_pass++;
    n_checks++; if (inst_o !== prev) $display("FAIL flush_hold got %h want %h", inst_o, prev); else n_pass++;
    fetch(32'h200, 0, w, lat);
    n_checks++; if (w !== exp_word(32'h200) || lat != 6)
      $display("FAIL flush_after got %h/%0d want %h/6", w, lat, exp_word(32'h200)); else n_pass++;
    // Flush on the final byte: no pulse, word not published.
    fetch(32'h240, 5, w, lat);
    n_checks++; if (lat != 0) $display("FAIL flush_last_valid got lat %0d want none", lat); else n_pass++;
    n_checks++; if (inst_o !== exp_word(32'h200)) $display("FAIL flush_last_hold got %h want %h", inst_o, exp_word(32'h200)); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    a = 32'hFFFF_FFFE;
    req_i = 1'b1; addr_i = a;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        n_checks++;
        if (mem_a_o !== a + 32'(c - 1) || mem_rd_o !== 1'b1)
          $display("FAIL wrap_addr c%0d got %h rd=%b want %h rd=1", c, mem_a_o, mem_rd_o, a + 32'(c - 1));
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== exp_word(a))
          $display("FAIL wrap_word got v=%b %h want v=1 %h", inst_valid_o, inst_o, exp_word(a));
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] w;
    int lat, nv;
    repeat (2) @(negedge clk);
    req_i = 1'b1; flush_i = 1'b1; addr_i = 32'h500;
    @(negedge clk);
    req_i = 1'b0; flush_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || mem_rd_o !== 1'b0)
      $display("FAIL simul_accept got busy=%b rd=%b want 0", busy_o, mem_rd_o); else n_pass++;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (inst_valid_o === 1'b1) nv++;
      @(negedge clk);
    end
    n_checks++; if (nv != 0) $display("FAIL simul_novalid got %0d want 0", nv); else n_pass++;
    fetch(32'h500, 0, w, lat);
    n_checks++; if (w !== exp_word(32'h500) || lat != 6)
      $display("FAIL simul_retry got %h/%0d want %h/6", w, lat, exp_word(32'h500)); else n_pass++;
  endtask

  task automatic test_icache;
`ifdef ICACHE_EN
    logic [31:0] w;
    int lat, rd0;
    apply_reset();
    fetch(32'h40, 0, w, lat);
    n_checks++; if (w !== exp_word(32'h40) || lat != 6) $display("FAIL ic_miss got %h/%0d want %h/6", w, lat, exp_word(32'h40)); else n_pass++;
    rd0 = rd_cnt;
    fetch(32'h40, 0, w, lat);
    n_checks++; if (w !== exp_word(32'h40) || lat != 1) $display("FAIL ic_hit got %h/%0d want %h/1", w, lat, exp_word(32'h40)); else n_pass++;
    n_checks++; if (rd_cnt != rd0 || busy_o !== 1'b0 || mem_rd_o !== 1'b0)
      $display("FAIL ic_nomem got reads=%0d busy=%b want 0 0", rd_cnt - rd0, busy_o); else n_pass++;
    fetch(32'h40 + 32'(4 * LINES), 0, w, lat);
    n_checks++; if (lat != 6) $display("FAIL ic_evict got lat %0d want 6", lat); else n_pass++;
    fetch(32'h40, 0, w, lat);
    n_checks++; if (w !== exp_word(32'h40) || lat != 6) $display("FAIL ic_remiss got %h/%0d want %h/6", w, lat, exp_word(32'h40)); else n_pass++;
`endif
  endtask

  task automatic test_random;
    logic [31:0] a, w, last_word;
    int lat, fa, exp_lat;
    bit h;
    apply_reset();
    last_word = '0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        2: a = 32'h1000 + 32'(4 * $urandom_range(0, 3));
        default: a = 32'h1000 + 32'(4 * LINES * $urandom_range(0, 2));
      endcase
      h = model_hit(a);
      fa = (!h && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      exp_lat = (fa != 0) ? 0 : (h ? 1 : 6);
      fetch(a, fa, w, lat);
      n_checks++;
      if (lat != exp_lat) $display("FAIL rand_lat i%0d a=%h got %0d want %0d", i, a, lat, exp_lat);
      else n_pass++;
      if (fa != 0) begin
        n_checks++;
        if (inst_o !== last_word) $display("FAIL rand_hold i%0d got %h want %h", i, inst_o, last_word);
        else n_pass++;
      end else begin
        n_checks++;
        if (w !== exp_word(a)) $display("FAIL rand_word i%0d a=%h got %h want %h", i, a, w, exp_word(a));
        else n_pass++;
        last_word = exp_word(a);
        if (!h) model_fill(a);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_simultaneous();
    test_icache();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction fetch controller that sits directly upstream of the CPU core's instruction port (rom_addr / rom_ce / rom_data). It turns each 32-bit instruction request from the PC stage into four sequential byte reads on the 8-bit unified memory bus and returns the assembled little-endian word with a one-cycle valid pulse. Raises busy to stall the PC, and supports abort on branch redirect via flush.

Parameters:
ADDR_W, 32, width of the instruction address and of the memory address bus.
ICACHE_LINES, 64, number of one-word lines in the optional I-cache; power of 2, ≥2. Ignored unless ICACHE_EN is defined.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_i  in  1  fetch request from the PC stage (rom_ce); sampled only when ready.
addr_i  in  ADDR_W  instruction address; latched when a request is accepted.
flush_i  in  1  abort the in-flight fetch (branch redirect).
inst_o  out  32  assembled instruction; held until the next completion.
inst_valid_o  out  1  one-cycle pulse: inst_o is valid for the accepted request.
busy_o  out  1  high while a fetch is in flight; the PC must hold.
mem_a_o  out  ADDR_W  byte address to memory.
mem_rd_o  out  1  memory read strobe.
mem_din_i  in  8  read data, valid the cycle after the address is driven.

Behaviour:
- Reset: synchronous and active-high, as already decided. While rst=1 at a clock edge: state←IDLE, inst_o←0, inst_valid_o←0, mem_a_o←0, mem_rd_o←0, busy_o←0, byte counter←0. Reset mid-fetch discards all partial data.
- States: IDLE, FETCH (cnt 0..4), DONE.
- Ready (accepts a request) in IDLE and DONE; never in FETCH.
- Accept: ready && req_i && !flush_i at an edge → base←addr_i, cnt←0, state←FETCH.
- FETCH, cnt=k:
  - for k<4: mem_a_o=base+k (mod 2^ADDR_W) and mem_rd_o=1, both registered outputs.
  - for k≥1: mem_din_i captured into byte k-1.
  - k=4: mem_rd_o=0 and the last byte is captured; next state DONE.
- Byte order: byte0→inst_o[7:0] … byte3→inst_o[31:24]. inst_o is updated only on completion and never shows partial words.
- DONE: inst_valid_o=1 for exactly this cycle. With a new request accepted here the next state is FETCH (back-to-back); otherwise IDLE.
- Latency: request accepted at edge E → inst_valid_o high in cycle E+6. Throughput is one word per 6 cycles.
- busy_o=1 exactly when state==FETCH.
- flush_i=1 at an edge in any state → state←IDLE, mem_rd_o←0, and no inst_valid_o pulse for the aborted request. inst_o keeps its previous value.
- flush_i and req_i together → flush wins, the request is not accepted, and the PC re-requests the next cycle.
- Alignment is not checked. The address is used as given; byte addresses wrap at 2^ADDR_W.
- req_i is ignored in FETCH and is not queued.

Optional Feature:
Macro ICACHE_EN.
- Defined: adds a direct-mapped cache of ICACHE_LINES one-word lines.
  - index = base[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits; one valid bit per line.
  - On accept, tag/valid are looked up using addr_i.
  - Hit: state←DONE directly, inst_o←cached word, inst_valid_o the next cycle (latency 1), no memory access, busy_o stays 0.
  - Miss: normal FETCH. On reaching DONE the line is written (data, tag, valid=1).
  - An aborted (flushed) fetch does not fill.
  - rst clears all valid bits. flush_i does not invalidate.
- Undefined: no cache storage; every request takes the 6-cycle memory path. Port list is identical in both builds.

Test Plan:
- Reset: hold rst for 3 cycles mid-fetch → all outputs 0, state IDLE, no inst_valid_o afterwards without a new req_i.
- Single fetch: memory bytes 0x13,0x05,0x10,0x00 at addresses 0x100..0x103; req_i with addr_i=0x100 → mem_a_o=0x100..0x103 on cycles 1..4, inst_valid_o in cycle 6 with inst_o=0x00100513, busy_o high in cycles 1..5.
- Back-to-back: req_i held high with addr_i 0x0, then 0x4 → second request accepted in DONE; valid pulses exactly 6 cycles apart with correct words.
- Flush: flush_i asserted when cnt=2 → mem_rd_o low the next cycle, no valid pulse, inst_o unchanged. A later req_i to 0x200 completes normally.
- Wrap/simultaneous: req_i with addr_i=0xFFFFFFFE → mem_a_o sequence FFFFFFFE, FFFFFFFF, 0, 1. req_i+flush_i in the same IDLE cycle → not accepted.
- ICACHE_EN: fetch 0x40 (miss, 6 cycles), then 0x40 again → valid in 1 cycle, mem_rd_o stays 0. Fetch 0x40+4×ICACHE_LINES → miss and evicts; re-fetch of 0x40 misses.
